mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single memory bus between the fetch port (IF) and the load/store port (MEM). Each granted transaction is held on the bus until it completes. The block produces if_stall and mem_stall, which the hazard/stall logic combines into its pc_pause and pipe_pause decisions. Supports fetch cancellation on redirect (branch, jump, flush) without aborting the bus.

Parameters:
AW, 32, address width
DW, 32, data width; byte strobes are DW/8 bits
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits; range 1..15

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_req  input  1  fetch request; held until i_ack or i_kill
i_addr  input  AW  fetch address
i_kill  input  1  discard the pending or in-flight fetch (redirect)
i_ack  output  1  fetch complete; i_rdata valid this cycle
i_rdata  output  DW  fetch data
d_req  input  1  load/store request; held until d_ack
d_we  input  1  1 = store
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_wstrb  input  DW/8  store byte enables
d_ack  output  1  data access complete; d_rdata valid for loads
d_rdata  output  DW  load data
bus_req  output  1  bus transaction active
bus_we  output  1  bus write
bus_addr  output  AW  bus address
bus_wdata  output  DW  bus write data
bus_wstrb  output  DW/8  bus strobes; all zero on fetch and on load
bus_ack  input  1  bus completion, one cycle, any latency ≥1 cycle after bus_req rises
bus_rdata  input  DW  bus read data, valid with bus_ack
if_stall  output  1  = i_req & ~i_ack & ~i_kill
mem_stall  output  1  = d_req & ~d_ack

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY.
- Reset values: state IDLE; bus_req/bus_we 0; bus_addr/bus_wdata/bus_wstrb 0; starve_cnt 0; kill_flag 0.
- Acks and rdata are combinational (no extra latency):
  - i_ack = bus_ack & IBUSY & ~kill_flag & ~i_kill.
  - d_ack = bus_ack & DBUSY.
  - i_rdata = d_rdata = bus_rdata.
- IDLE grant, evaluated every cycle:
  - d_req & ~(i_req & ~i_kill & starve_cnt==STARVE_LIMIT) → latch the d_* fields into the bus_* registers and go to DBUSY.
  - Else i_req & ~i_kill → latch i_addr (we=0, strb=0) and go to IBUSY.
  - Else stay IDLE.
  - bus_req rises in the cycle after the grant decision.
- bus_* are registered and stay stable from grant until bus_ack. Requester inputs are ignored while busy.
- On bus_ack in IBUSY or DBUSY:
  - Drop bus_req in the next cycle.
  - Return to IDLE and clear kill_flag.
  - Minimum one IDLE cycle between transactions. A req still high after its ack is treated as a new request.
- Starvation counter starve_cnt:
  - On a data grant with i_req & ~i_kill high: increment, saturating at STARVE_LIMIT.
  - On a data grant with the fetch not waiting: clear.
  - On a fetch grant: clear.
- Kill handling:
  - i_kill in IDLE: blocks a fetch grant in that cycle; a data grant may still proceed.
  - i_kill in IBUSY without bus_ack: set kill_flag. The bus transaction completes normally and its ack is suppressed.
  - i_kill in the same cycle as bus_ack: ack suppressed.
  - i_kill in DBUSY: no effect.
- Reset mid-transaction returns everything to reset values immediately, including bus_req. The bus slave must tolerate bus_req dropping at reset.
- No simultaneous i_ack and d_ack, ever.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x100, slave acks 2 cycles after bus_req.
  - Required: bus_addr=0x100, bus_we=0, bus_wstrb=0; i_ack for exactly 1 cycle with i_rdata=bus_rdata; if_stall high until that cycle; one IDLE cycle follows.
- Store during a fetch wait:
  - Stimulus: d_req+i_req same cycle, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF.
  - Required: data granted first with bus_wdata/bus_wstrb matching; fetch granted after d_ack.
- Starvation:
  - Stimulus: i_req high, d_req held high continuously, STARVE_LIMIT=4.
  - Required: exactly 4 data transactions, then a fetch grant, then starve_cnt=0 and data resumes.
- Kill in flight:
  - Stimulus: fetch granted, i_kill pulse while IBUSY, bus_ack 3 cycles later.
  - Required: no i_ack, FSM returns to IDLE, next fetch granted normally. Repeat with i_kill coincident with bus_ack: i_ack stays 0.
- Reset mid-transaction:
  - Stimulus: rst asserted in DBUSY before bus_ack.
  - Required: next cycle bus_req=0, state IDLE, d_ack never pulses; after release, pending d_req is re-granted.
- Load:
  - Stimulus: d_we=0, bus_rdata=0x12345678 on ack.
  - Required: bus_wstrb=0, d_ack=1 with d_rdata=0x12345678; mem_stall low in the ack cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between the fetch port and the load/store port.
// Data wins by default; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_kill,
  output logic              i_ack,
  output logic [DW-1:0]     i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_wstrb,
  output logic              d_ack,
  output logic [DW-1:0]     d_rdata,
  // memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  output logic [DW/8-1:0]   bus_wstrb,
  input  logic              bus_ack,
  input  logic [DW-1:0]     bus_rdata,
  // stall feedback to hazard logic
  output logic              if_stall,
  output logic              mem_stall
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            kill_q, kill_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [SW-1:0]   bus_wstrb_q, bus_wstrb_d;

  logic            fetch_wait;
  logic            data_grant;

  assign fetch_wait = i_req & ~i_kill;
  assign data_grant = d_req & ~(fetch_wait & (starve_q == LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  // Grant selection and transaction tracking; bus fields only change on a grant.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    kill_d      = kill_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (data_grant) begin
          state_d     = DBUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          bus_wstrb_d = d_we ? d_wstrb : '0;
          if (!fetch_wait) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (fetch_wait) begin
          state_d     = IBUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = i_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
          starve_d    = '0;
        end
      end
      IBUSY: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          kill_d    = 1'b0;
        end else if (i_kill) begin
          kill_d = 1'b1;
        end
      end
      DBUSY: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          kill_d    = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        kill_d    = 1'b0;
      end
    endcase
  end

  // Completion is passed straight through so requesters see no extra latency.
  assign i_ack     = bus_ack & (state_q == IBUSY) & ~kill_q & ~i_kill;
  assign d_ack     = bus_ack & (state_q == DBUSY);
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

  assign if_stall  = i_req & ~i_ack & ~i_kill;
  assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with an in-bench bus slave
// whose ack latency is set per scenario.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_kill, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          bus_req, bus_we, bus_ack;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [SW-1:0] bus_wstrb;
  logic          if_stall, mem_stall;

  int            total = 0;
  int            bad = 0;
  int            lat;
  int            slave_cnt;
  logic [DW-1:0] slave_rdata;
  logic          prev_req;
  int            ngrant;
  logic [15:0]   gseq;
  logic          seen;
  logic          saw_iack;
  logic          saw_back;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: update the slave after the edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_ack) begin
      bus_ack   = 1'b0;
      bus_rdata = '0;
      slave_cnt = 0;
    end else if (bus_req) begin
      if (slave_cnt == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = slave_rdata;
      end else begin
        slave_cnt++;
      end
    end else begin
      slave_cnt = 0;
    end
    if (bus_req && !prev_req && ngrant < 16) begin
      gseq[ngrant] = (bus_addr == 32'h108);
      ngrant++;
    end
    prev_req = bus_req;
    #1;
  endtask

  task automatic wait_ack(input logic dside, output logic got_it);
    got_it = 1'b0;
    for (int k = 0; k < 20 && !got_it; k++) begin
      tick();
      got_it = dside ? d_ack : i_ack;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && bus_req; k++) tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_kill = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    bus_ack = 0; bus_rdata = '0; lat = 2; slave_cnt = 0; slave_rdata = '0;
    prev_req = 0; ngrant = 0; gseq = '0;
    tick(); tick();
    check("rst_bus_req", 64'(bus_req), 64'h0);
    check("rst_bus_we", 64'(bus_we), 64'h0);
    check("rst_bus_addr", 64'(bus_addr), 64'h0);
    check("rst_bus_wdata", 64'(bus_wdata), 64'h0);
    check("rst_bus_wstrb", 64'(bus_wstrb), 64'h0);
    rst = 1'b0;
    tick();

    // Single fetch, slave acks two cycles after bus_req rises
    lat = 2; slave_rdata = 32'hCAFEF00D;
    i_req = 1; i_addr = 32'h100;
    tick();
    check("f_bus_req", 64'(bus_req), 64'h1);
    check("f_bus_addr", 64'(bus_addr), 64'h100);
    check("f_bus_we", 64'(bus_we), 64'h0);
    check("f_bus_wstrb", 64'(bus_wstrb), 64'h0);
    check("f_stall1", 64'(if_stall), 64'h1);
    check("f_noack1", 64'(i_ack), 64'h0);
    tick();
    check("f_stall2", 64'(if_stall), 64'h1);
    check("f_noack2", 64'(i_ack), 64'h0);
    tick();
    check("f_ack", 64'(i_ack), 64'h1);
    check("f_rdata", 64'(i_rdata), 64'hCAFEF00D);
    check("f_stall_ack", 64'(if_stall), 64'h0);
    i_req = 0;
    tick();
    check("f_ack_1cyc", 64'(i_ack), 64'h0);
    check("f_idle_req", 64'(bus_req), 64'h0);
    tick();
    check("f_stay_idle", 64'(bus_req), 64'h0);

    // Store and fetch requested together: data first, fetch after d_ack
    lat = 1;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    i_req = 1; i_addr = 32'h104;
    tick();
    check("s_bus_we", 64'(bus_we), 64'h1);
    check("s_bus_addr", 64'(bus_addr), 64'h2000);
    check("s_bus_wdata", 64'(bus_wdata), 64'hDEADBEEF);
    check("s_bus_wstrb", 64'(bus_wstrb), 64'hF);
    check("s_mem_stall", 64'(mem_stall), 64'h1);
    check("s_if_stall", 64'(if_stall), 64'h1);
    wait_ack(1'b1, seen);
    check("s_d_ack", 64'(seen), 64'h1);
    check("s_no_i_ack", 64'(i_ack), 64'h0);
    d_req = 0; d_we = 0; d_wstrb = '0;
    tick();
    check("s_gap", 64'(bus_req), 64'h0);
    tick();
    check("s_fetch_req", 64'(bus_req), 64'h1);
    check("s_fetch_addr", 64'(bus_addr), 64'h104);
    check("s_fetch_we", 64'(bus_we), 64'h0);
    check("s_fetch_wstrb", 64'(bus_wstrb), 64'h0);
    wait_ack(1'b0, seen);
    check("s_i_ack", 64'(seen), 64'h1);
    i_req = 0;
    drain();

    // Starvation: both held high; expect D D D D I D D D D I
    rst = 1; tick(); rst = 0; tick();
    lat = 1; ngrant = 0; gseq = '0;
    i_req = 1; i_addr = 32'h108;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    for (int k = 0; k < 200 && ngrant < 10; k++) tick();
    check("st_ngrant", 64'(ngrant), 64'd10);
    check("st_seq", 64'(gseq[9:0]), 64'(10'b1000010000));
    i_req = 0; d_req = 0;
    drain();

    // Kill in IDLE blocks the fetch grant
    i_req = 1; i_kill = 1; i_addr = 32'h118;
    #1;
    check("ki_if_stall", 64'(if_stall), 64'h0);
    tick();
    check("ki_no_grant", 64'(bus_req), 64'h0);
    i_req = 0; i_kill = 0;
    tick();

    // Kill while in flight: bus completes, i_ack suppressed
    lat = 4; slave_rdata = 32'h0BADF00D;
    i_req = 1; i_addr = 32'h10C;
    tick();
    check("kf_grant", 64'(bus_req), 64'h1);
    i_kill = 1; i_req = 0;
    tick();
    i_kill = 0;
    saw_iack = 0; saw_back = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      saw_iack |= i_ack;
      saw_back |= bus_ack;
    end
    check("kf_bus_ack", 64'(saw_back), 64'h1);
    check("kf_no_i_ack", 64'(saw_iack), 64'h0);
    check("kf_idle", 64'(bus_req), 64'h0);
    lat = 1; slave_rdata = 32'h00C0FFEE;
    i_req = 1; i_addr = 32'h110;
    wait_ack(1'b0, seen);
    check("kf_next_ack", 64'(seen), 64'h1);
    check("kf_next_rdata", 64'(i_rdata), 64'h00C0FFEE);
    i_req = 0;
    drain();

    // Kill coincident with bus_ack
    lat = 2;
    i_req = 1; i_addr = 32'h114;
    saw_back = 0;
    for (int k = 0; k < 10 && !saw_back; k++) begin
      tick();
      saw_back = bus_ack;
    end
    check("kc_bus_ack", 64'(saw_back), 64'h1);
    i_kill = 1; i_req = 0;
    #1;
    check("kc_no_i_ack", 64'(i_ack), 64'h0);
    tick();
    i_kill = 0;
    check("kc_idle", 64'(bus_req), 64'h0);
    tick();

    // Reset mid data transaction
    lat = 5;
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'h11223344; d_wstrb = 4'h3;
    tick();
    check("r_busy", 64'(bus_req), 64'h1);
    tick();
    rst = 1;
    tick();
    check("r_req_drop", 64'(bus_req), 64'h0);
    check("r_no_d_ack", 64'(d_ack), 64'h0);
    tick();
    check("r_no_d_ack2", 64'(d_ack), 64'h0);
    rst = 0; lat = 1;
    tick();
    check("r_regrant", 64'(bus_req), 64'h1);
    check("r_regrant_addr", 64'(bus_addr), 64'h2004);
    check("r_regrant_strb", 64'(bus_wstrb), 64'h3);
    wait_ack(1'b1, seen);
    check("r_d_ack", 64'(seen), 64'h1);
    d_req = 0; d_we = 0;
    drain();

    // Load: strobes forced to zero, data returned in the ack cycle
    lat = 1; slave_rdata = 32'h12345678;
    d_req = 1; d_we = 0; d_addr = 32'h2008; d_wstrb = 4'hF; d_wdata = 32'hFFFFFFFF;
    tick();
    check("l_bus_we", 64'(bus_we), 64'h0);
    check("l_bus_wstrb", 64'(bus_wstrb), 64'h0);
    wait_ack(1'b1, seen);
    check("l_d_ack", 64'(seen), 64'h1);
    check("l_d_rdata", 64'(d_rdata), 64'h12345678);
    check("l_mem_stall", 64'(mem_stall), 64'h0);
    check("l_no_i_ack", 64'(i_ack), 64'h0);
    d_req = 0; d_wstrb = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
